// File: rtl/chunk_dram_fetcher_pkg.sv
// chunk_dram_fetcher_pkg: sizing constants and command types shared with the chunk address looper.
package chunk_dram_fetcher_pkg;
  localparam int GBW    = 32;
  localparam int VSIZE  = 32;
  localparam int DBW    = 16;
  localparam int CSIZE  = 1024;
  localparam int QDEPTH = 4;
  localparam int C_BW   = $clog2(CSIZE);
  localparam int LEN_BW = $clog2(VSIZE + 1);
  typedef enum logic [1:0] {CMD_FETCH = 2'd0, CMD_PAD = 2'd1, CMD_SKIP = 2'd2} cmd_type_e;
  // pop marks the entry that closes a fetched group and must consume its DRAM response
  typedef struct packed {
    logic [1:0]        ctype;
    logic [C_BW-1:0]   addrofs;
    logic [LEN_BW-1:0] len;
    logic              pop;
  } q_entry_t;
endpackage

// File: rtl/chunk_fetch_queue.sv
// chunk_fetch_queue: small FIFO of accepted commands waiting for their DRAM data or retirement.
module chunk_fetch_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk_i)
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/chunk_dram_fetcher.sv
// chunk_dram_fetcher: issues one DRAM read per command group and writes masked lines to the cache.
// Defining CHUNK_FETCH_PERF_EN adds saturating request/stall counters.
module chunk_dram_fetcher
  import chunk_dram_fetcher_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 cmd_rdy,
  output logic                 cmd_ack,
  input  logic [1:0]           i_cmd_type,
  input  logic                 i_cmd_islast,
  input  logic [GBW-1:0]       i_cmd_addr,
  input  logic [C_BW-1:0]      i_cmd_addrofs,
  input  logic [LEN_BW-1:0]    i_cmd_len,
  output logic                 dramra_rdy,
  input  logic                 dramra_ack,
  output logic [GBW-1:0]       o_dramra,
  input  logic                 dramrd_rdy,
  output logic                 dramrd_ack,
  input  logic [VSIZE*DBW-1:0] i_dramrd,
  output logic                 o_sram_we,
  output logic [C_BW-1:0]      o_sram_waddr,
  output logic [VSIZE-1:0]     o_sram_wmask,
`ifdef CHUNK_FETCH_PERF_EN
  output logic [31:0]          o_perf_nreq,
  output logic [31:0]          o_perf_stall,
`endif
  output logic [VSIZE*DBW-1:0] o_sram_wdata
);
  q_entry_t             push_ent, head;
  logic                 q_full, q_empty, need_req, needs_data, retire;
  logic                 grp_fetched_q, grp_fetched_d, ra_rdy_q, ra_rdy_d, we_q, we_d;
  logic [GBW-1:0]       ra_addr_q, ra_addr_d;
  logic [C_BW-1:0]      waddr_q, waddr_d;
  logic [VSIZE-1:0]     wmask_q, wmask_d;
  logic [VSIZE*DBW-1:0] wdata_q, wdata_d;

  chunk_fetch_queue #(.W($bits(q_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk_i(i_clk), .rst_ni(i_rst_n), .push_i(cmd_ack), .pop_i(retire),
    .din_i(push_ent), .dout_o(head), .full_o(q_full), .empty_o(q_empty)
  );

  // a new request may load in the same cycle the pending one is acked
  always_comb begin
    need_req      = i_cmd_type == CMD_FETCH && !grp_fetched_q;
    cmd_ack       = i_rst_n && cmd_rdy && !q_full && !(need_req && ra_rdy_q && !dramra_ack);
    push_ent      = '{ctype: i_cmd_type, addrofs: i_cmd_addrofs, len: i_cmd_len,
                      pop: i_cmd_islast && (grp_fetched_q || i_cmd_type == CMD_FETCH)};
    grp_fetched_d = !cmd_ack ? grp_fetched_q : i_cmd_islast ? 1'b0 : grp_fetched_q || i_cmd_type == CMD_FETCH;
    ra_rdy_d      = cmd_ack && need_req ? 1'b1 : dramra_ack ? 1'b0 : ra_rdy_q;
    ra_addr_d     = cmd_ack && need_req ? i_cmd_addr : ra_addr_q;
    needs_data    = head.pop || head.ctype == CMD_FETCH;
    retire        = !q_empty && (!needs_data || dramrd_rdy);
    dramrd_ack    = retire && head.pop;
    we_d          = retire && (head.ctype == CMD_FETCH || head.ctype == CMD_PAD);
    waddr_d       = we_d ? head.addrofs : waddr_q;
    wdata_d       = !we_d ? wdata_q : head.ctype == CMD_FETCH ? i_dramrd : '0;
    wmask_d       = wmask_q;
    for (int i = 0; i < VSIZE; i++) if (we_d) wmask_d[i] = LEN_BW'(i) < head.len;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      grp_fetched_q <= 1'b0;
      ra_rdy_q      <= 1'b0;
      ra_addr_q     <= '0;
      we_q          <= 1'b0;
      waddr_q       <= '0;
      wmask_q       <= '0;
      wdata_q       <= '0;
    end else begin
      grp_fetched_q <= grp_fetched_d;
      ra_rdy_q      <= ra_rdy_d;
      ra_addr_q     <= ra_addr_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wmask_q       <= wmask_d;
      wdata_q       <= wdata_d;
    end

  assign dramra_rdy   = ra_rdy_q;
  assign o_dramra     = ra_addr_q;
  assign o_sram_we    = we_q;
  assign o_sram_waddr = waddr_q;
  assign o_sram_wmask = wmask_q;
  assign o_sram_wdata = wdata_q;

`ifdef CHUNK_FETCH_PERF_EN
  logic [31:0] nreq_q, stall_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      nreq_q  <= '0;
      stall_q <= '0;
    end else begin
      if (ra_rdy_q && dramra_ack && !(&nreq_q)) nreq_q <= nreq_q + 32'd1;
      if (cmd_rdy && !cmd_ack && !(&stall_q)) stall_q <= stall_q + 32'd1;
    end
  assign o_perf_nreq  = nreq_q;
  assign o_perf_stall = stall_q;
`endif
endmodule
